// File: rtl/piece_drop_ctrl.sv
// Piece drop controller: converts gravity ticks and the held down-key into step-down
// pulses, runs the lock-delay window, then locks, respawns and detects game over.
module piece_drop_ctrl #(
    parameter int GRAVITY_DIV = 8,
    parameter int FAST_DIV    = 2,
    parameter int LOCK_DELAY  = 4,
    parameter int CNT_W       = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic pause,
    input  logic downKey,
    input  logic blocked,
    input  logic spawnBlocked,
    output logic stepDown,
    output logic lockPiece,
    output logic resetPiece,
    output logic spawn,
    output logic gameOver
);

    typedef enum logic [2:0] {
        IDLE,
        SPAWN,
        FALL,
        LOCK,
        LOCKOUT,
        OVER
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] gcnt, gcnt_nxt;
    logic [CNT_W-1:0] lcnt, lcnt_nxt;
    logic [CNT_W-1:0] period_m1;
    logic             tick;

    // >= rather than == so a switch to fast mode with gcnt already past the fast
    // limit ticks at once instead of waiting for the counter to wrap.
    assign period_m1 = downKey ? CNT_W'(FAST_DIV - 1) : CNT_W'(GRAVITY_DIV - 1);
    assign tick      = (gcnt >= period_m1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            gcnt  <= '0;
            lcnt  <= '0;
        end else begin
            state <= state_nxt;
            gcnt  <= gcnt_nxt;
            lcnt  <= lcnt_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        gcnt_nxt   = gcnt;
        lcnt_nxt   = lcnt;
        stepDown   = 1'b0;
        lockPiece  = 1'b0;
        resetPiece = 1'b0;
        spawn      = 1'b0;
        gameOver   = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SPAWN;
                end
            end
            SPAWN: begin
                spawn = 1'b1;
                if (spawnBlocked) begin
                    state_nxt = OVER;
                end else begin
                    state_nxt = FALL;
                    gcnt_nxt  = '0;
                end
            end
            FALL: begin
                if (!pause) begin
                    if (!tick) begin
                        gcnt_nxt = gcnt + CNT_W'(1);
                    end else if (!blocked) begin
                        stepDown = 1'b1;
                        gcnt_nxt = '0;
                    end else begin
                        state_nxt = LOCK;
                        lcnt_nxt  = '0;
                    end
                end
            end
            LOCK: begin
                // Sliding off the ledge beats a hard drop, which beats the timer.
                if (!pause) begin
                    if (!blocked) begin
                        state_nxt = FALL;
                        gcnt_nxt  = '0;
                    end else if (downKey) begin
                        state_nxt = LOCKOUT;
                    end else if (lcnt == CNT_W'(LOCK_DELAY - 1)) begin
                        state_nxt = LOCKOUT;
                    end else begin
                        lcnt_nxt = lcnt + CNT_W'(1);
                    end
                end
            end
            LOCKOUT: begin
                lockPiece  = 1'b1;
                resetPiece = 1'b1;
                state_nxt  = SPAWN;
            end
            OVER: begin
                gameOver = 1'b1;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Outputs stay quiet while reset is held, whatever the current state.
        if (reset) begin
            stepDown   = 1'b0;
            lockPiece  = 1'b0;
            resetPiece = 1'b0;
            spawn      = 1'b0;
            gameOver   = 1'b0;
        end
    end

endmodule
